// File: rtl/node_list_replay_pkg.sv
// Shared types for the sorted node list capture/replay buffer.
// Default build sizes the list for 1024 nodes.
package node_list_replay_pkg;

    localparam int DEF_MAX_NODES   = 1024;
    localparam int DEF_NODE_WIDTH  = $clog2(DEF_MAX_NODES);
    localparam int DEF_COUNT_WIDTH = DEF_NODE_WIDTH + 1;

    typedef logic [DEF_NODE_WIDTH-1:0]  node_t;
    typedef logic [DEF_COUNT_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        CAPTURE,
        READY,
        REPLAY,
        DONE
    } replay_state_t;

endpackage

// File: rtl/node_list_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Array contents are not reset; only the read register is.
module node_list_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Holds the last read word while rd_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/node_list_replay.sv
// Captures the sorted node list once and replays it on request.
// NODE_LIST_REPLAY_REVERSE_EN adds replay_reverse for backward replay.
module node_list_replay
    import node_list_replay_pkg::*;
#(
    parameter int MAX_NODES   = DEF_MAX_NODES,
    parameter int NODE_WIDTH  = $clog2(MAX_NODES),
    parameter int COUNT_WIDTH = NODE_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    input  logic [NODE_WIDTH-1:0]  wr_node,
    input  logic                   wr_done,
    input  logic                   list_clear,
    input  logic                   replay_req,
`ifdef NODE_LIST_REPLAY_REVERSE_EN
    input  logic                   replay_reverse,
`endif
    output logic                   replay_ready,
    output logic                   sorted_valid,
    output logic [NODE_WIDTH-1:0]  sorted_node,
    output logic                   sorted_done,
    output logic [COUNT_WIDTH-1:0] node_count,
    output logic                   overflow
);

    replay_state_t state, state_nxt;

    logic [COUNT_WIDTH-1:0] wr_ptr;
    logic [COUNT_WIDTH-1:0] rd_addr;
    logic [COUNT_WIDTH-1:0] rd_idx;
    logic                   cap;
    logic                   full;
    logic                   wr_en;
    logic                   start;
    logic                   rd_more;
    logic                   rd_en;
    logic                   valid_q;
    logic                   rev_q;

    assign cap     = (state == CAPTURE);
    assign full    = (wr_ptr == COUNT_WIDTH'(MAX_NODES));
    assign wr_en   = cap && wr_valid && !full && !list_clear;
    assign start   = (state == READY) && replay_req;
    assign rd_more = (rd_addr != node_count);
    assign rd_en   = (state == REPLAY) && rd_more && !list_clear;

    assign rd_idx = rev_q ? node_count - COUNT_WIDTH'(1) - rd_addr
                          : rd_addr;

    assign replay_ready = (state == READY);
    assign sorted_done  = (state == DONE);
    assign sorted_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CAPTURE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CAPTURE: if (wr_done)    state_nxt = READY;
            READY:   if (replay_req) state_nxt = REPLAY;
            REPLAY:  if (!rd_more)   state_nxt = DONE;
            DONE:                    state_nxt = READY;
        endcase
        if (list_clear) state_nxt = CAPTURE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_addr    <= '0;
            node_count <= '0;
            overflow   <= 1'b0;
            valid_q    <= 1'b0;
        end else if (list_clear) begin
            wr_ptr     <= '0;
            rd_addr    <= '0;
            node_count <= '0;
            overflow   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (wr_en) wr_ptr <= wr_ptr + COUNT_WIDTH'(1);
            if (cap && wr_valid && full) overflow <= 1'b1;
            // Last node may arrive together with wr_done
            if (cap && wr_done)
                node_count <= wr_ptr + COUNT_WIDTH'(wr_en);
            if (start)      rd_addr <= '0;
            else if (rd_en) rd_addr <= rd_addr + COUNT_WIDTH'(1);
        end
    end

`ifdef NODE_LIST_REPLAY_REVERSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rev_q <= 1'b0;
        else if (start) rev_q <= replay_reverse;
    end
`else
    assign rev_q = 1'b0;
`endif

    node_list_ram #(
        .DEPTH (MAX_NODES),
        .WIDTH (NODE_WIDTH),
        .AW    (NODE_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[NODE_WIDTH-1:0]),
        .wr_data (wr_node),
        .rd_en   (rd_en),
        .rd_addr (rd_idx[NODE_WIDTH-1:0]),
        .rd_data (sorted_node)
    );

endmodule

// File: tb/tb_node_list_replay.sv
// Directed bench for node_list_replay with a 16-entry list.
// Define NODE_LIST_REPLAY_REVERSE_EN to also cover backward replay.
module tb_node_list_replay;

    localparam int MAXN = 16;
    localparam int NW   = 4;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [NW-1:0] wr_node = '0;
    logic          wr_done = 1'b0;
    logic          list_clear = 1'b0;
    logic          replay_req = 1'b0;
    logic          replay_reverse = 1'b0;
    logic          replay_ready;
    logic          sorted_valid;
    logic [NW-1:0] sorted_node;
    logic          sorted_done;
    logic [CW-1:0] node_count;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    logic [NW-1:0] wl [0:31];
    logic [NW-1:0] exp_n [0:15];

    always #5 clk = ~clk;

    node_list_replay #(.MAX_NODES(MAXN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_node      (wr_node),
        .wr_done      (wr_done),
        .list_clear   (list_clear),
        .replay_req   (replay_req),
`ifdef NODE_LIST_REPLAY_REVERSE_EN
        .replay_reverse (replay_reverse),
`endif
        .replay_ready (replay_ready),
        .sorted_valid (sorted_valid),
        .sorted_node  (sorted_node),
        .sorted_done  (sorted_done),
        .node_count   (node_count),
        .overflow     (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writes wl[0..n-1], wr_done on the last valid (or alone if n==0)
    task automatic write_list(input int n);
        if (n == 0) begin
            wr_done = 1'b1;
            tick();
        end
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_node  = wl[i];
            wr_done  = (i == n - 1);
            tick();
        end
        wr_valid = 1'b0;
        wr_done  = 1'b0;
    endtask

    // Replays and checks exp_n[0..n-1]; hold_req keeps replay_req high
    task automatic run_replay(input string tag, input int n,
                              input bit rev, input bit hold_req);
        replay_req     = 1'b1;
        replay_reverse = rev;
        tick();
        replay_req = (n > 0) ? hold_req : 1'b0;
        chk({tag, " t1 valid"}, 32'(sorted_valid), 0);
        chk({tag, " t1 ready"}, 32'(replay_ready), 0);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == n - 1) replay_req = 1'b0;
            chk($sformatf("%s valid%0d", tag, i), 32'(sorted_valid), 1);
            chk($sformatf("%s node%0d", tag, i), 32'(sorted_node),
                32'(exp_n[i]));
            chk($sformatf("%s nodone%0d", tag, i), 32'(sorted_done), 0);
        end
        tick();
        chk({tag, " done"}, 32'(sorted_done), 1);
        chk({tag, " done valid"}, 32'(sorted_valid), 0);
        if (n > 0)
            chk({tag, " done node"}, 32'(sorted_node), 32'(exp_n[n-1]));
        tick();
        chk({tag, " ready after"}, 32'(replay_ready), 1);
        chk({tag, " done once"}, 32'(sorted_done), 0);
        chk({tag, " idle valid"}, 32'(sorted_valid), 0);
    endtask

    task automatic clear();
        list_clear = 1'b1;
        tick();
        list_clear = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst ready", 32'(replay_ready), 0);
        chk("rst valid", 32'(sorted_valid), 0);
        chk("rst done", 32'(sorted_done), 0);
        chk("rst node", 32'(sorted_node), 0);
        chk("rst count", 32'(node_count), 0);
        chk("rst ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // Basic list 5,2,7,1,9
        wl[0] = 4'd5; wl[1] = 4'd2; wl[2] = 4'd7;
        wl[3] = 4'd1; wl[4] = 4'd9;
        for (int i = 0; i < 5; i++) exp_n[i] = wl[i];
        chk("cap ready before", 32'(replay_ready), 0);
        write_list(5);
        chk("cap count", 32'(node_count), 5);
        chk("cap ready", 32'(replay_ready), 1);
        wr_valid = 1'b1; wr_node = 4'd3; wr_done = 1'b1;
        tick();
        wr_valid = 1'b0; wr_done = 1'b0;
        chk("ready ignores wr", 32'(node_count), 5);
        run_replay("r1", 5, 1'b0, 1'b0);
        run_replay("r2", 5, 1'b0, 1'b0);
        run_replay("r3 req held", 5, 1'b0, 1'b1);

        // Empty list
        clear();
        chk("clr ready", 32'(replay_ready), 0);
        chk("clr count", 32'(node_count), 0);
        write_list(0);
        chk("empty count", 32'(node_count), 0);
        chk("empty ready", 32'(replay_ready), 1);
        run_replay("empty", 0, 1'b0, 1'b0);

        // Overflow: 18 writes into 16 entries
        clear();
        for (int i = 0; i < 18; i++) wl[i] = 4'((i * 3) % 16);
        for (int i = 0; i < 16; i++) exp_n[i] = 4'((i * 3) % 16);
        write_list(18);
        chk("ovf flag", 32'(overflow), 1);
        chk("ovf count", 32'(node_count), 16);
        run_replay("ovf", 16, 1'b0, 1'b0);
        chk("ovf sticky", 32'(overflow), 1);

        // Clear in the middle of a replay
        clear();
        chk("clr ovf", 32'(overflow), 0);
        wl[0] = 4'd5; wl[1] = 4'd2; wl[2] = 4'd7;
        wl[3] = 4'd1; wl[4] = 4'd9;
        write_list(5);
        replay_req = 1'b1;
        tick();
        replay_req = 1'b0;
        repeat (3) tick();
        chk("abort pre valid", 32'(sorted_valid), 1);
        chk("abort pre node", 32'(sorted_node), 7);
        clear();
        chk("abort valid", 32'(sorted_valid), 0);
        chk("abort done", 32'(sorted_done), 0);
        chk("abort ready", 32'(replay_ready), 0);
        tick();
        chk("abort no done", 32'(sorted_done), 0);
        chk("abort count", 32'(node_count), 0);
        wl[0] = 4'd3; wl[1] = 4'd4;
        exp_n[0] = 4'd3; exp_n[1] = 4'd4;
        write_list(2);
        chk("recap count", 32'(node_count), 2);
        run_replay("recap", 2, 1'b0, 1'b0);

        // Async reset in the middle of a replay
        replay_req = 1'b1;
        tick();
        replay_req = 1'b0;
        tick();
        chk("arst pre valid", 32'(sorted_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid", 32'(sorted_valid), 0);
        chk("arst node", 32'(sorted_node), 0);
        chk("arst ready", 32'(replay_ready), 0);
        chk("arst count", 32'(node_count), 0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef NODE_LIST_REPLAY_REVERSE_EN
        wl[0] = 4'd5; wl[1] = 4'd2; wl[2] = 4'd7;
        exp_n[0] = 4'd7; exp_n[1] = 4'd2; exp_n[2] = 4'd5;
        write_list(3);
        run_replay("rev", 3, 1'b1, 1'b0);
        exp_n[0] = 4'd5; exp_n[1] = 4'd2; exp_n[2] = 4'd7;
        run_replay("fwd after rev", 3, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
